inst_buffer: RTL and testbench

- Registered FIFO that is the producer side of the decoder's inst/valid interface.
- Accepts fetched instructions with their PC/NPC from the fetch stage and presents them in program order to the dispatch-stage decoder under a valid/ready handshake.
- Flushes on branch-mispredict squash.
- Stops presenting instructions after a WFI has been handed off.

---
 rtl/inst_buffer_pkg.sv | 18 +
 rtl/inst_buffer_if.sv | 34 +++
 rtl/inst_buffer_ptr_ctrl.sv | 63 ++++++
 rtl/inst_buffer.sv | 88 ++++++++
 tb/tb_inst_buffer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the dispatch-side instruction buffer.
// An entry carries the instruction word together with its PC and predicted NPC.
package inst_buffer_pkg;

   localparam int IB_DEPTH = 8;

   typedef logic [31:0] inst_t;

   localparam inst_t IB_NOP_INST = 32'h0000_0013;
   localparam inst_t IB_WFI_INST = 32'h1050_0073;

   typedef struct packed {
      inst_t       inst;
      logic [31:0] pc;
      logic [31:0] npc;
   } ib_entry_t;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-to-buffer and buffer-to-dispatch handshake bundle.
// The buffer takes the slave view; the fetch/dispatch environment takes the master view.
interface inst_buffer_if
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = IB_DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          squash;
   logic          if_valid;
   inst_t         if_inst;
   logic [31:0]   if_pc;
   logic [31:0]   if_npc;
   logic          if_ready;
   logic          id_ready;
   logic          id_valid;
   inst_t         id_inst;
   logic [31:0]   id_pc;
   logic [31:0]   id_npc;
   logic [CW-1:0] count;
   logic          halted;

   modport slave (
      input  squash, if_valid, if_inst, if_pc, if_npc, id_ready,
      output if_ready, id_valid, id_inst, id_pc, id_npc, count, halted
   );

   modport master (
      output squash, if_valid, if_inst, if_pc, if_npc, id_ready,
      input  if_ready, id_valid, id_inst, id_pc, id_npc, count, halted
   );

endinterface

// File: rtl/inst_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the instruction buffer.
// Squash overrides any push or pop offered in the same cycle.
module inst_buffer_ptr_ctrl #(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          squash_i,
   input  logic          push_i,
   input  logic          pop_i,
   output logic [PW-1:0] head_o,
   output logic [PW-1:0] tail_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   // Next-state pointers; PW-bit adds wrap modulo DEPTH on their own.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (squash_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d = pop_i  ? head_q + PW'(1) : head_q;
         tail_d = push_i ? tail_q + PW'(1) : tail_q;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_buffer.sv
// In-order instruction buffer between fetch and dispatch, with squash flush
// and a halt latch that stops dispatch once a WFI has been handed off.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int    DEPTH    = IB_DEPTH,
   parameter inst_t NOP_INST = IB_NOP_INST,
   parameter inst_t WFI_INST = IB_WFI_INST
) (
   input logic        clock,
   input logic        reset,
   inst_buffer_if.slave ib
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   ib_entry_t        mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             halted_q, halted_d;

   logic [PW-1:0]    head_s, tail_s;
   logic [CW-1:0]    count_s;
   logic             full_s, empty_s;
   logic             push_s, pop_s, id_valid_s;
   logic [DEPTH-1:0] set_s, clr_s;
   ib_entry_t        head_entry_s;

   inst_buffer_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clock    (clock),
      .reset    (reset),
      .squash_i (ib.squash),
      .push_i   (push_s),
      .pop_i    (pop_s),
      .head_o   (head_s),
      .tail_o   (tail_s),
      .count_o  (count_s),
      .full_o   (full_s),
      .empty_o  (empty_s)
   );

   assign head_entry_s = mem_q[head_s];
   assign id_valid_s   = !empty_s && !halted_q && valid_q[head_s];
   assign push_s       = ib.if_valid && !full_s;
   assign pop_s        = id_valid_s && ib.id_ready;
   assign set_s        = DEPTH'(push_s) << tail_s;
   assign clr_s        = DEPTH'(pop_s) << head_s;

   // Slot valid bits and halt latch; a squashed pop never counts as a WFI hand-off.
   always_comb begin
      valid_d  = valid_q;
      halted_d = halted_q;
      if (ib.squash) begin
         valid_d  = '0;
         halted_d = 1'b0;
      end else begin
         valid_d  = (valid_q & ~clr_s) | set_s;
         halted_d = halted_q || (pop_s && (head_entry_s.inst == WFI_INST));
      end
   end

   // Control state registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   // Payload storage needs no reset: the valid bits qualify every slot.
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_q[tail_s] <= '{inst: ib.if_inst, pc: ib.if_pc, npc: ib.if_npc};
      end
   end

   assign ib.if_ready = !full_s;
   assign ib.id_valid = id_valid_s;
   assign ib.id_inst  = id_valid_s ? head_entry_s.inst : NOP_INST;
   assign ib.id_pc    = id_valid_s ? head_entry_s.pc   : 32'h0;
   assign ib.id_npc   = id_valid_s ? head_entry_s.npc  : 32'h0;
   assign ib.count    = count_s;
   assign ib.halted   = halted_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: the driver queues expected entries as it offers
// them, the negedge monitor compares the head and status outputs and pops on hand-off.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic clock = 1'b0;
   logic reset;

   inst_buffer_if #(.DEPTH(DEPTH)) ib ();

   inst_buffer #(.DEPTH(DEPTH), .NOP_INST(IB_NOP_INST), .WFI_INST(IB_WFI_INST)) dut (
      .clock (clock),
      .reset (reset),
      .ib    (ib)
   );

   always #5 clock = ~clock;

   int          checks   = 0;
   int          failures = 0;
   ib_entry_t   exp_q[$];
   logic [31:0] disp_pcs[$];
   int          exp_cnt  = 0;
   bit          halt_m   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: occupancy model is the queue length; the head of the queue is the expected head.
   always @(negedge clock) begin
      ib_entry_t e;
      bit        exp_valid;
      if (reset) begin
         exp_q.delete();
         halt_m = 1'b0;
      end else begin
         exp_valid = (exp_cnt > 0) && !halt_m;
         chk("count",    32'(ib.count),    32'(exp_cnt));
         chk("if_ready", 32'(ib.if_ready), 32'(exp_cnt < DEPTH));
         chk("halted",   32'(ib.halted),   32'(halt_m));
         chk("id_valid", 32'(ib.id_valid), 32'(exp_valid));
         if (exp_valid && exp_q.size() > 0) begin
            chk("head_inst", ib.id_inst, exp_q[0].inst);
            chk("head_pc",   ib.id_pc,   exp_q[0].pc);
            chk("head_npc",  ib.id_npc,  exp_q[0].npc);
         end else begin
            chk("idle_inst", ib.id_inst, IB_NOP_INST);
            chk("idle_pc",   ib.id_pc,   32'h0);
            chk("idle_npc",  ib.id_npc,  32'h0);
         end
         if (ib.squash) begin
            exp_q.delete();
            halt_m = 1'b0;
         end else if (exp_valid && ib.id_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            disp_pcs.push_back(e.pc);
            if (e.inst == IB_WFI_INST) halt_m = 1'b1;
         end
      end
   end

   // One clock of stimulus; the entry is queued only if the buffer has room and no squash.
   task automatic cycle(input bit sq, input bit iv, input bit ir,
                        input logic [31:0] inst, input logic [31:0] pc);
      @(posedge clock);
      #1;
      exp_cnt     = exp_q.size();
      ib.squash   = sq;
      ib.if_valid = iv;
      ib.id_ready = ir;
      ib.if_inst  = inst;
      ib.if_pc    = pc;
      ib.if_npc   = pc + 32'd4;
      if (iv && !sq && exp_cnt < DEPTH)
         exp_q.push_back('{inst: inst, pc: pc, npc: pc + 32'd4});
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      int cnt_w;
      int pushed;
      bit iv, ir;

      reset = 1'b1;
      ib.squash = 1'b0; ib.if_valid = 1'b0; ib.id_ready = 1'b0;
      ib.if_inst = 32'h0; ib.if_pc = 32'h0; ib.if_npc = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_if_ready", 32'(ib.if_ready), 32'd1);
      chk("rst_id_valid", 32'(ib.id_valid), 32'd0);
      chk("rst_id_inst",  ib.id_inst, IB_NOP_INST);
      chk("rst_count",    32'(ib.count), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_cnt = 0;

      // Three pushes held at the head, then drained in order.
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, 1'b0, 32'h0010_0093 + 32'(i) * 32'h0010_0080, 32'(i * 4));
      idle();
      chk("t1_count", 32'(ib.count), 32'd3);
      chk("t1_pc",    ib.id_pc,   32'h0);
      chk("t1_inst",  ib.id_inst, 32'h0010_0093);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      idle();
      chk("t1_empty_valid", 32'(ib.id_valid), 32'd0);
      chk("t1_empty_inst",  ib.id_inst, 32'h0000_0013);

      // Fill to full; a push offered while full is dropped even alongside a pop.
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 1'b0, $urandom, 32'h200 + 32'(i * 4));
      cycle(1'b0, 1'b1, 1'b0, $urandom, 32'h220);
      chk("t2_full_ready", 32'(ib.if_ready), 32'd0);
      chk("t2_full_count", 32'(ib.count), 32'd8);
      cycle(1'b0, 1'b1, 1'b1, $urandom, 32'h224);
      chk("t2_no_ninth", 32'(ib.count), 32'd8);
      cycle(1'b0, 1'b1, 1'b1, $urandom, 32'h228);
      chk("t2_pop_only", 32'(ib.count), 32'd7);
      idle();
      chk("t2_push_pop", 32'(ib.count), 32'd7);
      repeat (8) cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      idle();

      // Wrap: 20 pushes with occupancy kept in 1..5.
      disp_pcs.delete();
      cnt_w = 0;
      pushed = 0;
      while (pushed < 20 || cnt_w > 0) begin
         ir = (cnt_w >= 2 || (pushed == 20 && cnt_w > 0)) && ($urandom_range(0, 1) == 1 || pushed == 20);
         iv = (pushed < 20) && (cnt_w < 5) && ($urandom_range(0, 3) != 0 || cnt_w <= 1);
         cycle(1'b0, iv, ir, $urandom & 32'hFFFF_FF7F, 32'(pushed * 4));
         if (iv) pushed++;
         cnt_w = cnt_w + int'(iv) - int'(ir);
      end
      idle();
      idle();
      chk("t3_disp_n", 32'(disp_pcs.size()), 32'd20);
      for (int i = 0; i < 20 && i < disp_pcs.size(); i++)
         chk("t3_disp_pc", disp_pcs[i], 32'(i * 4));

      // Squash with count=5 alongside a push and a pop.
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b1, 1'b0, $urandom, 32'h180 + 32'(i * 4));
      cycle(1'b1, 1'b1, 1'b1, $urandom, 32'h194);
      cycle(1'b0, 1'b1, 1'b0, 32'h0010_0093, 32'h100);
      chk("t4_count", 32'(ib.count), 32'd0);
      chk("t4_valid", 32'(ib.id_valid), 32'd0);
      chk("t4_ready", 32'(ib.if_ready), 32'd1);
      idle();
      chk("t4_head_pc", ib.id_pc, 32'h100);
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      idle();

      // WFI hand-off halts dispatch; fetch may still fill; squash releases.
      cycle(1'b0, 1'b1, 1'b1, IB_WFI_INST, 32'h300);
      cycle(1'b0, 1'b1, 1'b1, 32'h0010_0093, 32'h304);
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk("t5_halted", 32'(ib.halted), 32'd1);
      chk("t5_valid",  32'(ib.id_valid), 32'd0);
      chk("t5_count",  32'(ib.count), 32'd1);
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 1'b1, $urandom, 32'h308 + 32'(i * 4));
      idle();
      chk("t5_fill_ready", 32'(ib.if_ready), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();
      chk("t5_unhalt", 32'(ib.halted), 32'd0);
      chk("t5_flush",  32'(ib.count), 32'd0);

      // Asynchronous reset mid-cycle with count=4 and halted=1.
      cycle(1'b0, 1'b1, 1'b1, IB_WFI_INST, 32'h400);
      cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b1, 1'b0, $urandom, 32'h404 + 32'(i * 4));
      idle();
      chk("t6_pre_count",  32'(ib.count), 32'd4);
      chk("t6_pre_halted", 32'(ib.halted), 32'd1);
      #2;
      reset = 1'b1;
      exp_cnt = 0;
      #1;
      chk("t6_count",    32'(ib.count), 32'd0);
      chk("t6_halted",   32'(ib.halted), 32'd0);
      chk("t6_if_ready", 32'(ib.if_ready), 32'd1);
      chk("t6_id_valid", 32'(ib.id_valid), 32'd0);
      chk("t6_id_inst",  ib.id_inst, IB_NOP_INST);
      chk("t6_id_pc",    ib.id_pc, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Random traffic with occasional WFI and squash.
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               ($urandom_range(0, 15) == 0) ? IB_WFI_INST : $urandom, $urandom & 32'hFFFF_FFFC);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
